alu_op_sequencer: RTL

Command-side controller for the 16-bit ALU output mux. It accepts a binary opcode and operands over a valid/ready handshake. It encodes the opcode into the 12-bit one-hot select the mux decodes, drives the operand buses and holds the select for a programmable settle time. It then captures the mux result, flags and accumulator, and presents the result over a second valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the ALU output mux: accepts an opcode, drives a one-hot
// select and operands for a settle period, captures the result and hands it off.
module alu_op_sequencer #(
  parameter int WIDTH  = 16,
  parameter int SEL_W  = 12,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             sub_mode,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic             res_err,
  output logic [WIDTH-1:0] acc
);

  // A settle of 0 behaves as 1; values above the counter range saturate.
  localparam logic [3:0] SETTLE_EFF = (SETTLE < 1)  ? 4'd1 :
                                      (SETTLE > 15) ? 4'd15 : 4'(SETTLE);
  localparam logic [4:0] NUM_OPS    = 5'(SEL_W);
  localparam logic [3:0] OP_ADD     = 4'd7;
  localparam logic [3:0] OP_SUB     = 4'd8;
  localparam logic [3:0] OP_CLEAR   = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [3:0]       cnt_r;
  logic [3:0]       op_r;
  logic [SEL_W-1:0] sel_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic             sub_mode_r;
  logic [WIDTH-1:0] res_data_r;
  logic             res_carry_r;
  logic             res_err_r;
  logic [WIDTH-1:0] acc_r;
  logic             accept_s;
  logic             legal_s;
  logic             capture_s;

  function automatic logic op_is_legal(input logic [3:0] op);
    return ({1'b0, op} < NUM_OPS);
  endfunction

  function automatic logic [SEL_W-1:0] op_to_sel(input logic [3:0] op);
    logic [SEL_W-1:0] s;
    s = {SEL_W{1'b0}};
    for (int i = 0; i < SEL_W; i++) begin
      s[i] = (op == 4'(i));
    end
    return s;
  endfunction

  assign accept_s  = cmd_valid && (state_r == IDLE);
  assign legal_s   = op_is_legal(cmd_op);
  // Counter <= 1 also ends ISSUE so a corrupted count can never stall the FSM.
  assign capture_s = (state_r == ISSUE) && (cnt_r <= 4'd1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = legal_s ? ISSUE : RESP;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (capture_s) begin
          state_s = RESP;
        end else begin
          state_s = ISSUE;
        end
      end
      RESP: begin
        if (res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    if (rst) begin
      cmd_ready = 1'b0;
    end else begin
      cmd_ready = (state_r == IDLE);
    end
    res_valid = (state_r == RESP);
    res_zero  = (res_data_r == {WIDTH{1'b0}});
  end

  // Command latch, settle counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= 4'd0;
      op_r        <= 4'd0;
      sel_r       <= {SEL_W{1'b0}};
      op_a_r      <= {WIDTH{1'b0}};
      op_b_r      <= {WIDTH{1'b0}};
      sub_mode_r  <= 1'b0;
      res_data_r  <= {WIDTH{1'b0}};
      res_carry_r <= 1'b0;
      res_err_r   <= 1'b0;
      acc_r       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r   <= cmd_op;
            op_a_r <= cmd_use_acc ? acc_r : cmd_a;
            op_b_r <= cmd_b;
            if (legal_s) begin
              sel_r      <= op_to_sel(cmd_op);
              sub_mode_r <= (cmd_op == OP_SUB);
              cnt_r      <= SETTLE_EFF;
            end else begin
              res_err_r   <= 1'b1;
              res_data_r  <= {WIDTH{1'b0}};
              res_carry_r <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (capture_s) begin
            // CLEAR ignores the mux output entirely.
            res_data_r  <= (op_r == OP_CLEAR) ? {WIDTH{1'b0}} : alu_res;
            acc_r       <= (op_r == OP_CLEAR) ? {WIDTH{1'b0}} : alu_res;
            res_carry_r <= ((op_r == OP_ADD) || (op_r == OP_SUB)) ? alu_carry : 1'b0;
            res_err_r   <= 1'b0;
            sel_r       <= {SEL_W{1'b0}};
            sub_mode_r  <= 1'b0;
            cnt_r       <= 4'd0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          cnt_r <= 4'd0;
        end
        default: begin
          sel_r      <= {SEL_W{1'b0}};
          sub_mode_r <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = sel_r;
  assign op_a      = op_a_r;
  assign op_b      = op_b_r;
  assign sub_mode  = sub_mode_r;
  assign res_data  = res_data_r;
  assign res_carry = res_carry_r;
  assign res_err   = res_err_r;
  assign acc       = acc_r;

endmodule
